// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte producers. Each producer has a
// one-deep pending slot; a grant FSM issues one byte at a time around tx_busy.

module uart_tx_slot (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic       launch,
  input  logic [7:0] data_in,
  output logic       pending,
  output logic       pending_nxt,
  output logic [7:0] data,
  output logic       overwrite
);
  logic       pending_q, pending_d;
  logic [7:0] data_q, data_d;

  // A strobe landing on the launch cycle refills the slot rather than being dropped.
  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    if (valid) begin
      pending_d = 1'b1;
      data_d    = data_in;
    end else if (launch) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending_q <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign pending     = pending_q;
  assign pending_nxt = pending_d;
  assign data        = data_q;
  assign overwrite   = valid & pending_q & ~launch;
endmodule

module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ROUND_ROBIN  = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_pending,
  output logic [NUM_REQ-1:0]   req_sent,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [7:0]           drop_count,
  output logic                 sched_idle
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      tx_start_q, tx_start_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]        req_sent_q, req_sent_d;
  logic [7:0]                drop_q, drop_d;
  logic                      sched_idle_q, sched_idle_d;

  logic [NUM_REQ-1:0]        slot_pend, slot_pend_nxt, slot_ovr, launch;
  logic [NUM_REQ-1:0][7:0]   slot_data;
  logic                      win_found;
  logic [IDX_W-1:0]          win_idx, cand_idx;
  int                        cand;
  logic [3:0]                ovr_num;
  logic [8:0]                drop_sum;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    uart_tx_slot u_slot (
      .clock       (clock),
      .reset       (reset),
      .valid       (req_valid[i]),
      .launch      (launch[i]),
      .data_in     (req_data[8*i +: 8]),
      .pending     (slot_pend[i]),
      .pending_nxt (slot_pend_nxt[i]),
      .data        (slot_data[i]),
      .overwrite   (slot_ovr[i])
    );
  end

  // Winner search: fixed priority scans from slot 0, round-robin from pointer+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (ROUND_ROBIN != 0) ? (int'(rr_ptr_q) + 1 + k) : k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && slot_pend[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Outputs are registered, so the launch strobe is set up on the IDLE->LAUNCH edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    req_sent_d = '0;
    launch     = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          state_d           = LAUNCH;
          tx_start_d        = 1'b1;
          tx_data_d         = slot_data[win_idx];
          req_sent_d[win_idx] = 1'b1;
          launch[win_idx]   = 1'b1;
          rr_ptr_d          = win_idx;
        end
      end
      LAUNCH: begin
        cnt_d   = 8'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(BUSY_TIMEOUT)) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_num = '0;
    for (int i = 0; i < NUM_REQ; i++) ovr_num = ovr_num + 4'(slot_ovr[i]);
    drop_sum     = {1'b0, drop_q} + {5'b0, ovr_num};
    drop_d       = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    sched_idle_d = (state_d == IDLE) && (slot_pend_nxt == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      req_sent_q   <= '0;
      drop_q       <= 8'd0;
      sched_idle_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      req_sent_q   <= req_sent_d;
      drop_q       <= drop_d;
      sched_idle_q <= sched_idle_d;
    end
  end

  assign req_pending = slot_pend;
  assign req_sent    = req_sent_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign drop_count  = drop_q;
  assign sched_idle  = sched_idle_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: cycle table plus multi-cycle sequences,
// with a fixed-priority instance and a round-robin instance.

module tb_uart_tx_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_pending, req_sent;
  logic        tx_start, tx_busy, sched_idle;
  logic [7:0]  tx_data, drop_count;
  logic        man_busy = 1'b0, bfm_busy = 1'b0, bfm_en = 1'b0;
  int          bfm_cnt = 0;

  logic [3:0]  rr_valid = '0;
  logic [31:0] rr_data = 32'h0000_B1B0;
  logic [3:0]  rr_pending, rr_sent;
  logic        rr_start, rr_idle;
  logic [7:0]  rr_txd, rr_drop;

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] st_data[$];
  int         st_cyc[$];
  logic [3:0] st_sent[$];
  logic       st_busy[$];

  assign tx_busy = bfm_en ? bfm_busy : man_busy;

  uart_tx_scheduler #(.NUM_REQ(4), .ROUND_ROBIN(0), .BUSY_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_pending(req_pending), .req_sent(req_sent), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .drop_count(drop_count), .sched_idle(sched_idle));

  uart_tx_scheduler #(.NUM_REQ(4), .ROUND_ROBIN(1), .BUSY_TIMEOUT(16)) dut_rr (
    .clock(clock), .reset(reset), .req_valid(rr_valid), .req_data(rr_data),
    .req_pending(rr_pending), .req_sent(rr_sent), .tx_start(rr_start), .tx_data(rr_txd),
    .tx_busy(1'b0), .drop_count(rr_drop), .sched_idle(rr_idle));

  always #5 clock = ~clock;

  // Launch monitor and UART busy model: busy rises right after a start, lasts 10 cycles.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (tx_start) begin
      st_data.push_back(tx_data);
      st_cyc.push_back(cyc);
      st_sent.push_back(req_sent);
      st_busy.push_back(tx_busy);
    end
    if (bfm_cnt > 0) begin
      bfm_cnt--;
      if (bfm_cnt == 0) bfm_busy = 1'b0;
    end
    if (bfm_en && tx_start) begin
      bfm_busy = 1'b1;
      bfm_cnt  = 10;
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  e_pend;
    logic        e_start;
    logic [7:0]  e_data;
    logic [3:0]  e_sent;
    logic [7:0]  e_drop;
    logic        e_idle;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    man_busy  = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (st_data.size() < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk(nm, 32'(st_data.size()), 32'(n));
  endtask

  initial begin
    int base, fall_cyc, n_rr_start;
    logic [3:0] g_slot[$];
    logic [7:0] g_data[$];

    //        valid  data          busy pend  st  data   sent  drop   idle
    tbl[0]  = '{4'h2, 32'h0000_3200, 1'b0, 4'h2, 1'b0, 8'h00, 4'h0, 8'd0, 1'b0};
    tbl[1]  = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b1, 8'h32, 4'h2, 8'd0, 1'b0};
    tbl[2]  = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h32, 4'h0, 8'd0, 1'b0};
    tbl[3]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 8'h32, 4'h0, 8'd0, 1'b0};
    tbl[4]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 8'h32, 4'h0, 8'd0, 1'b0};
    tbl[5]  = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h32, 4'h0, 8'd0, 1'b1};
    tbl[6]  = '{4'h4, 32'h0041_0000, 1'b1, 4'h4, 1'b0, 8'h32, 4'h0, 8'd0, 1'b0};
    tbl[7]  = '{4'h4, 32'h0042_0000, 1'b1, 4'h4, 1'b0, 8'h32, 4'h0, 8'd1, 1'b0};
    tbl[8]  = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b1, 8'h42, 4'h4, 8'd1, 1'b0};
    tbl[9]  = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h42, 4'h0, 8'd1, 1'b0};
    tbl[10] = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 8'h42, 4'h0, 8'd1, 1'b0};
    tbl[11] = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h42, 4'h0, 8'd1, 1'b1};
    tbl[12] = '{4'h1, 32'h0000_0011, 1'b0, 4'h1, 1'b0, 8'h42, 4'h0, 8'd1, 1'b0};
    tbl[13] = '{4'h1, 32'h0000_0022, 1'b0, 4'h1, 1'b1, 8'h11, 4'h1, 8'd1, 1'b0};
    tbl[14] = '{4'h0, 32'h0,         1'b1, 4'h1, 1'b0, 8'h11, 4'h0, 8'd1, 1'b0};
    tbl[15] = '{4'h0, 32'h0,         1'b1, 4'h1, 1'b0, 8'h11, 4'h0, 8'd1, 1'b0};
    tbl[16] = '{4'h0, 32'h0,         1'b0, 4'h1, 1'b0, 8'h11, 4'h0, 8'd1, 1'b0};
    tbl[17] = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b1, 8'h22, 4'h1, 8'd1, 1'b0};
    tbl[18] = '{4'h0, 32'h0,         1'b0, 4'h0, 1'b0, 8'h22, 4'h0, 8'd1, 1'b0};

    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("rst_pending", 32'(req_pending), 32'h0);
    chk("rst_start",   32'(tx_start),    32'h0);
    chk("rst_data",    32'(tx_data),     32'h0);
    chk("rst_sent",    32'(req_sent),    32'h0);
    chk("rst_drop",    32'(drop_count),  32'h0);
    chk("rst_idle",    32'(sched_idle),  32'h1);

    // Round-robin: slots 0 and 1 re-strobed as soon as each is sent.
    rr_valid = 4'b0011;
    @(negedge clock);
    rr_valid = '0;
    n_rr_start = 0;
    for (int c = 0; c < 400 && g_slot.size() < 8; c++) begin
      @(negedge clock);
      rr_valid = rr_sent & 4'b0011;
      if (rr_start) n_rr_start++;
      if (rr_sent != 0) begin
        g_slot.push_back(rr_sent);
        g_data.push_back(rr_txd);
      end
    end
    rr_valid = '0;
    chk("rr_count", 32'(g_slot.size()), 32'd8);
    chk("rr_starts", 32'(n_rr_start), 32'(g_slot.size()));
    for (int i = 0; i < g_slot.size(); i++) begin
      chk($sformatf("rr_slot%0d", i), 32'(g_slot[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("rr_data%0d", i), 32'(g_data[i]), (i % 2 == 0) ? 32'hB0 : 32'hB1);
    end
    chk("rr_drop", 32'(rr_drop), 32'h0);
    chk("rr_pending_end", 32'(rr_pending), 32'h1);
    chk("rr_idle_end", 32'(rr_idle), 32'h0);

    // Cycle table: latency, overwrite, launch-cycle refill.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      req_valid = tbl[i].valid;
      req_data  = tbl[i].data;
      man_busy  = tbl[i].busy;
      @(negedge clock);
      chk($sformatf("v%0d_pending", i), 32'(req_pending), 32'(tbl[i].e_pend));
      chk($sformatf("v%0d_start", i),   32'(tx_start),    32'(tbl[i].e_start));
      chk($sformatf("v%0d_data", i),    32'(tx_data),     32'(tbl[i].e_data));
      chk($sformatf("v%0d_sent", i),    32'(req_sent),    32'(tbl[i].e_sent));
      chk($sformatf("v%0d_drop", i),    32'(drop_count),  32'(tbl[i].e_drop));
      chk($sformatf("v%0d_idle", i),    32'(sched_idle),  32'(tbl[i].e_idle));
    end

    // Fixed priority with busy model.
    do_reset();
    base = st_data.size();
    bfm_en = 1'b1;
    req_valid = 4'b1101;
    req_data  = {8'h52, 8'h34, 8'h00, 8'h30};
    @(negedge clock);
    req_valid = '0;
    wait_starts(base + 3, 80, "fp_count");
    if (st_data.size() >= base + 3) begin
      chk("fp_byte0", 32'(st_data[base]),   32'h30);
      chk("fp_byte1", 32'(st_data[base+1]), 32'h34);
      chk("fp_byte2", 32'(st_data[base+2]), 32'h52);
      chk("fp_sent0", 32'(st_sent[base]),   32'h1);
      chk("fp_sent2", 32'(st_sent[base+2]), 32'h8);
      for (int i = 0; i < 3; i++) chk($sformatf("fp_busy%0d", i), 32'(st_busy[base+i]), 32'h0);
      chk("fp_gap01", 32'(st_cyc[base+1] - st_cyc[base] >= 12), 32'h1);
      chk("fp_gap12", 32'(st_cyc[base+2] - st_cyc[base+1] >= 12), 32'h1);
    end
    repeat (15) @(negedge clock);
    bfm_en = 1'b0;

    // Busy timeout: tx_busy held low.
    do_reset();
    base = st_data.size();
    req_valid = 4'b1010;
    req_data  = {8'hA3, 8'h00, 8'hA1, 8'h00};
    @(negedge clock);
    req_valid = '0;
    wait_starts(base + 2, 60, "to_count");
    if (st_data.size() >= base + 2) begin
      chk("to_byte0", 32'(st_data[base]),   32'hA1);
      chk("to_byte1", 32'(st_data[base+1]), 32'hA3);
      chk("to_sent0", 32'(st_sent[base]),   32'h2);
      chk("to_sent1", 32'(st_sent[base+1]), 32'h8);
      chk("to_gap",   32'(st_cyc[base+1] - st_cyc[base]), 32'd18);
    end

    // Overwrites under busy: multi-slot sum, then saturation.
    do_reset();
    base = st_data.size();
    man_busy  = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h4433_2211;
    @(negedge clock);
    req_data  = 32'h8877_6655;
    @(negedge clock);
    req_valid = '0;
    chk("ov_multi_drop", 32'(drop_count), 32'd4);
    chk("ov_pending",    32'(req_pending), 32'hF);
    req_data = 32'h88C2_6655;
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'b0100;
      @(negedge clock);
      if (i == 39) chk("ov_drop44", 32'(drop_count), 32'd44);
    end
    req_valid = '0;
    chk("ov_sat", 32'(drop_count), 32'd255);
    chk("ov_no_start", 32'(st_data.size()), 32'(base));
    man_busy = 1'b0;
    wait_starts(base + 1, 6, "ov_release");
    if (st_data.size() >= base + 1) chk("ov_first_byte", 32'(st_data[base]), 32'h55);

    // Reset during WAIT_DONE with a pending slot and a nonzero drop count.
    do_reset();
    base = st_data.size();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0055;
    @(negedge clock);
    req_valid = '0;
    wait_starts(base + 1, 6, "mr_first");
    man_busy  = 1'b1;
    req_valid = 4'b0010;
    req_data  = 32'h0000_6600;
    @(negedge clock);
    req_data  = 32'h0000_6700;
    @(negedge clock);
    req_valid = '0;
    chk("mr_pre_pending", 32'(req_pending), 32'h2);
    chk("mr_pre_drop",    32'(drop_count),  32'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("mr_pending", 32'(req_pending), 32'h0);
    chk("mr_drop",    32'(drop_count),  32'h0);
    chk("mr_start",   32'(tx_start),    32'h0);
    chk("mr_idle",    32'(sched_idle),  32'h1);
    base = st_data.size();
    req_valid = 4'b1000;
    req_data  = 32'h7700_0000;
    @(negedge clock);
    req_valid = '0;
    repeat (5) @(negedge clock);
    chk("mr_hold_off", 32'(st_data.size()), 32'(base));
    man_busy = 1'b0;
    fall_cyc = cyc;
    wait_starts(base + 1, 8, "mr_after_fall");
    if (st_data.size() >= base + 1) begin
      chk("mr_byte", 32'(st_data[base]), 32'h77);
      chk("mr_after_busy", 32'(st_cyc[base] > fall_cyc), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter between several byte producers, for example the mole-position reporter, the game-over 'R' sender and a score reporter.
- Each producer gets a one-deep pending slot.
- A grant FSM issues one byte at a time to the transmitter and sequences around its busy flag.
- Sits in the top level between producer logic and the uart_tx instance, replacing ad-hoc tx_start/tx_data priority muxing.

Parameters:
- NUM_REQ, 4, number of requester slots (2..8).
- ROUND_ROBIN, 0, arbitration mode: 0 = fixed priority (slot 0 highest), 1 = round-robin.
- BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before the byte is treated as sent (1..255).

Ports:
- clock  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  one-cycle request strobe per slot.
- req_data  in  8*NUM_REQ  byte per slot; slot i uses bits [8i+7:8i].
- req_pending  out  NUM_REQ  slot i holds an unsent byte.
- req_sent  out  NUM_REQ  one-cycle pulse when slot i's byte is launched.
- tx_start  out  1  one-cycle launch strobe to the UART transmitter.
- tx_data  out  8  byte to the transmitter; held stable between launches.
- tx_busy  in  1  transmitter busy flag.
- drop_count  out  8  saturating count of overwritten bytes.
- sched_idle  out  1  high when the FSM is in IDLE and no slot is pending.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All slots cleared.
  - tx_start=0, tx_data=0, req_sent=0, drop_count=0, req_pending=0.
  - FSM goes to IDLE, timeout counter 0.
  - The round-robin pointer is set to NUM_REQ-1, so slot 0 is served first.
  - All outputs are registered.
- Slot capture, evaluated per slot each cycle:
  - req_valid[i] with the slot empty: latch the byte; pending=1 next cycle.
  - req_valid[i] with the slot pending and not launched this cycle: overwrite the byte (latest wins); drop_count+1, saturating at 255. Several simultaneous overwrites add their total, still saturating.
  - req_valid[i] in the same cycle slot i is launched: the old byte goes out, the new byte is latched, pending stays 1, no drop.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if any slot is pending and tx_busy=0, choose the winner, register its index, go to LAUNCH. Otherwise stay.
  - LAUNCH (exactly 1 cycle):
    - tx_start=1 and tx_data=winner byte.
    - Clear the winner's pending bit and pulse req_sent[winner].
    - Update the round-robin pointer to the winner.
    - Clear the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1: go to WAIT_DONE.
    - Otherwise increment the counter; when it reaches BUSY_TIMEOUT, go to IDLE (byte considered sent, no retry).
  - WAIT_DONE: tx_busy=0 moves the FSM to IDLE; no timeout in this state.
- Arbitration:
  - ROUND_ROBIN=0: the lowest-index pending slot wins.
  - ROUND_ROBIN=1: search starts at pointer+1 and wraps modulo NUM_REQ.
  - The winner is chosen from the pending bits visible in IDLE. A byte captured in the same cycle is not eligible until the next cycle.
- Latency, from req_valid at cycle 0 with the FSM in IDLE, all slots empty and tx_busy=0:
  - Pending at cycle 1.
  - tx_start high during cycle 2.
  - Minimum spacing between consecutive tx_start pulses is 4 cycles (LAUNCH, WAIT_BUSY, WAIT_DONE, IDLE).
- Reset mid-operation:
  - Pending bytes are discarded and the FSM goes to IDLE.
  - No tx_start is issued while tx_busy=1 after reset, so an in-flight UART frame is never corrupted.
- tx_busy already high in IDLE: launching is held off until it falls.
- sched_idle = (state==IDLE) && (req_pending==0).

Test Plan:
- Single request, defaults: req_valid[1] with data 0x32 at cycle 0, tx_busy=0 → req_pending[1] high at cycle 1; at cycle 2 tx_start=1, tx_data=0x32, req_sent[1]=1; pending cleared.
- Fixed priority:
  - Stimulus: slots 3, 0 and 2 strobed together (data 'R', '0', '4'); BFM raises tx_busy 1 cycle after tx_start and holds it 10 cycles.
  - Required: bytes sent in order '0', '4', 'R'; tx_start pulses at least 12 cycles apart; no start while tx_busy=1.
- Round-robin, ROUND_ROBIN=1:
  - Stimulus: slots 0 and 1 re-strobed immediately after each req_sent.
  - Required: grants alternate 0, 1, 0, 1 over 8 bytes; first grant goes to slot 0 after reset.
- Overwrite and saturation:
  - Stimulus: hold tx_busy=1; strobe slot 2 with 0x41 then 0x42; release tx_busy.
  - Required: only 0x42 is sent; drop_count=1.
  - Stimulus: a further 300 overwrites.
  - Required: drop_count saturates at 255.
- Busy timeout: tx_busy tied 0, two slots pending → each launch waits exactly 16 cycles in WAIT_BUSY, then the next launch follows; both bytes appear with their req_sent pulses.
- Reset mid-frame:
  - Stimulus: reset=0 for 1 cycle during WAIT_DONE with tx_busy=1 and slot 1 pending.
  - Required: all pending bits 0; drop_count=0; no tx_start until tx_busy falls and a new request arrives.
